// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  // Which requester owns the read data returning from the RAM this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  // Access is bad when it falls outside the RAM or is not word aligned
  function automatic logic is_bad_addr(input logic [DATA_W-1:0] addr,
                                       input int unsigned addr_w);
    logic [DATA_W-1:0] upper;
    upper = addr >> (addr_w + $clog2(WORD_BYTES));
    return (upper != '0) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the shared RAM port arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_stall;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_stall;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_err;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_stall, if_rvalid, if_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_stall, mem_rvalid, mem_rdata, mem_err,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // Pipeline stages and RAM side
  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_stall, if_rvalid, if_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_stall, mem_rvalid, mem_rdata, mem_err,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and load/store.
// Default: MEM has priority, a starvation counter forces one IF win after
// STARVE_MAX consecutive IF losses.
// MEM_ARB_ROUND_ROBIN_EN: round-robin on contested cycles, no counter.
module mem_arb_prio #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic mem_req,
  output logic if_win_c,
  output logic mem_win_c
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_if_q;
  logic contested_c;

  // Loser of the last contested cycle wins the next contested one
  always_comb begin
    contested_c = if_req & mem_req;
    if_win_c    = contested_c ? ~last_if_q : if_req;
    mem_win_c   = mem_req & ~if_win_c;
  end

  // Last-winner register, updated only when both requested
  always_ff @(posedge clk) begin
    if (reset) last_if_q <= 1'b1;
    else if (contested_c) last_if_q <= if_win_c;
  end
`else
  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             force_if_c;

  // Fixed MEM priority, overridden once IF has lost STARVE_MAX times in a row
  always_comb begin
    force_if_c = (cnt_q == CNT_W'(STARVE_MAX));
    if_win_c   = if_req & (~mem_req | force_if_c);
    mem_win_c  = mem_req & ~if_win_c;
    cnt_d      = (~if_req | if_win_c) ? '0 : cnt_q + CNT_W'(1);
  end

  // Starvation counter
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the IF and MEM stages.
// Grants and the RAM port are combinational; read data returns one cycle
// after the grant and is routed to the owner recorded at grant time.
// Optional: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  logic        if_req_c;
  logic        mem_req_c;
  logic        if_win_c;
  logic        mem_win_c;
  logic        any_win_c;
  logic        win_bad_c;
  logic        port_en_c;
  logic [31:0] win_addr_c;
  owner_t      owner_d;
  owner_t      owner_q;
  logic        bad_q;
  logic        err_q;
  logic [31:0] resp_data_c;
  logic        if_rvalid_c;
  logic        mem_rvalid_c;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;

  // Requests are ignored while reset is held so every output stays 0
  assign if_req_c  = bus.if_req & ~reset;
  assign mem_req_c = bus.mem_req & ~reset;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req_c),
    .mem_req  (mem_req_c),
    .if_win_c (if_win_c),
    .mem_win_c(mem_win_c)
  );

  // Grant, stall and RAM port drive from the winner
  always_comb begin
    any_win_c     = if_win_c | mem_win_c;
    win_addr_c    = mem_win_c ? bus.mem_addr : bus.if_addr;
    win_bad_c     = any_win_c & is_bad_addr(win_addr_c, ADDR_W);
    port_en_c     = any_win_c & ~win_bad_c;
    bus.if_gnt    = if_win_c;
    bus.mem_gnt   = mem_win_c;
    bus.if_stall  = if_req_c & ~if_win_c;
    bus.mem_stall = mem_req_c & ~mem_win_c;
    bus.ram_en    = port_en_c;
    bus.ram_we    = port_en_c & mem_win_c & bus.mem_we;
    bus.ram_addr  = port_en_c ? win_addr_c[ADDR_W+1:2] : '0;
    bus.ram_wdata = (port_en_c & mem_win_c & bus.mem_we) ? bus.mem_wdata : '0;
  end

  // Owner of next cycle's read data; a fetch flushed at grant gets none
  always_comb begin
    owner_d = OWN_NONE;
    if (if_win_c & ~bus.if_flush)   owner_d = OWN_IF;
    else if (mem_win_c & ~bus.mem_we) owner_d = OWN_MEM;
  end

  // Response routing; bad reads return zero, flush drops a due fetch
  always_comb begin
    resp_data_c    = bad_q ? '0 : bus.ram_rdata;
    if_rvalid_c    = (owner_q == OWN_IF) & ~bus.if_flush & ~reset;
    mem_rvalid_c   = (owner_q == OWN_MEM) & ~reset;
    bus.if_rvalid  = if_rvalid_c;
    bus.mem_rvalid = mem_rvalid_c;
    bus.if_rdata   = reset ? '0 : (if_rvalid_c ? resp_data_c : if_rdata_q);
    bus.mem_rdata  = reset ? '0 : (mem_rvalid_c ? resp_data_c : mem_rdata_q);
    bus.mem_err    = err_q & ~reset;
  end

  // Response owner, error pulse and read-data hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      bad_q       <= win_bad_c;
      err_q       <= win_bad_c;
      if_rdata_q  <= if_rvalid_c ? resp_data_c : if_rdata_q;
      mem_rdata_q <= mem_rvalid_c ? resp_data_c : mem_rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] ram [1024];
  logic [31:0] bad_list [3];

  mem_port_arbiter_if #(.ADDR_W(10)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (10),
    .STARVE_MAX(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
  endtask

  task automatic test_reset();
    checks++; if ({bus.if_gnt, bus.if_stall, bus.if_rvalid, bus.mem_gnt, bus.mem_stall, bus.mem_rvalid, bus.mem_err, bus.ram_en, bus.ram_we} !== 9'b0)
      $display("FAIL reset_ctrl: got %b want 0", {bus.if_gnt, bus.if_stall, bus.if_rvalid, bus.mem_gnt, bus.mem_stall, bus.mem_rvalid, bus.mem_err, bus.ram_en, bus.ram_we}); else passes++;
    checks++; if ({bus.if_rdata, bus.mem_rdata} !== 64'b0) $display("FAIL reset_rdata: got %h want 0", {bus.if_rdata, bus.mem_rdata}); else passes++;
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.if_req = 1; bus.if_addr = 32'h10 + 32'(4 * i);
      #1;
      checks++; if ({bus.if_gnt, bus.if_stall, bus.ram_en, bus.ram_we} !== 4'b1010) $display("FAIL fetch_gnt%0d: got %b want 1010", i, {bus.if_gnt, bus.if_stall, bus.ram_en, bus.ram_we}); else passes++;
      checks++; if (bus.ram_addr !== 10'(4 + i)) $display("FAIL fetch_addr%0d: got %0d want %0d", i, bus.ram_addr, 4 + i); else passes++;
      if (i > 0) begin
        checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0000 + 32'(3 + i))
          $display("FAIL fetch_resp%0d: got %b/%h want 1/%h", i, bus.if_rvalid, bus.if_rdata, 32'hA000_0000 + 32'(3 + i)); else passes++;
      end
    end
    cyc(); idle(); #1;
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0006) $display("FAIL fetch_last: got %b/%h want 1/a0000006", bus.if_rvalid, bus.if_rdata); else passes++;
    cyc();
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'hA000_0006) $display("FAIL fetch_hold: got %b/%h want 0/a0000006", bus.if_rvalid, bus.if_rdata); else passes++;
  endtask

  task automatic test_conflict();
    cyc();
    bus.if_req = 1; bus.if_addr = 32'h30; bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h20;
    #1;
    checks++; if ({bus.mem_gnt, bus.mem_stall, bus.if_gnt, bus.if_stall} !== 4'b1001) $display("FAIL conflict_gnt: got %b want 1001", {bus.mem_gnt, bus.mem_stall, bus.if_gnt, bus.if_stall}); else passes++;
    checks++; if (bus.ram_addr !== 10'd8) $display("FAIL conflict_addr: got %0d want 8", bus.ram_addr); else passes++;
    cyc(); idle(); #1;
    checks++; if (bus.mem_rvalid !== 1'b1 || bus.mem_rdata !== 32'hA000_0008 || bus.if_rvalid !== 1'b0)
      $display("FAIL conflict_resp: got %b/%h if_rvalid %b want 1/a0000008 0", bus.mem_rvalid, bus.mem_rdata, bus.if_rvalid); else passes++;
  endtask

  task automatic test_starvation();
    cyc();
    bus.if_req = 1; bus.if_addr = 32'h34; bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h24;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if ({bus.if_gnt, bus.mem_gnt, bus.mem_stall} !== ((k == 4) ? 3'b101 : 3'b010))
        $display("FAIL starve_c%0d: got %b want %b", k, {bus.if_gnt, bus.mem_gnt, bus.mem_stall}, (k == 4) ? 3'b101 : 3'b010); else passes++;
      if (k == 5) begin
        checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_000D) $display("FAIL starve_resp: got %b/%h want 1/a000000d", bus.if_rvalid, bus.if_rdata); else passes++;
      end
      cyc();
    end
    idle();
    cyc();
  endtask

  task automatic test_store_load();
    cyc();
    bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 32'h40; bus.mem_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if ({bus.mem_gnt, bus.ram_en, bus.ram_we} !== 3'b111 || bus.ram_addr !== 10'd16 || bus.ram_wdata !== 32'hDEAD_BEEF)
      $display("FAIL store_port: got %b %0d %h want 111 16 deadbeef", {bus.mem_gnt, bus.ram_en, bus.ram_we}, bus.ram_addr, bus.ram_wdata); else passes++;
    cyc();
    bus.mem_we = 0;
    #1;
    checks++; if (bus.mem_rvalid !== 1'b0 || bus.ram_we !== 1'b0 || bus.mem_gnt !== 1'b1) $display("FAIL store_norvalid: got rvalid %b we %b gnt %b want 0 0 1", bus.mem_rvalid, bus.ram_we, bus.mem_gnt); else passes++;
    cyc(); idle(); #1;
    checks++; if (bus.mem_rvalid !== 1'b1 || bus.mem_rdata !== 32'hDEAD_BEEF || bus.mem_err !== 1'b0)
      $display("FAIL load_back: got %b/%h err %b want 1/deadbeef 0", bus.mem_rvalid, bus.mem_rdata, bus.mem_err); else passes++;
  endtask

  task automatic test_top_word();
    cyc();
    bus.mem_req = 1; bus.mem_addr = 32'hFFC;
    #1;
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 10'd1023) $display("FAIL top_port: got %b %0d want 1 1023", bus.ram_en, bus.ram_addr); else passes++;
    cyc(); idle(); #1;
    checks++; if (bus.mem_rvalid !== 1'b1 || bus.mem_rdata !== 32'hA000_03FF || bus.mem_err !== 1'b0)
      $display("FAIL top_resp: got %b/%h err %b want 1/a00003ff 0", bus.mem_rvalid, bus.mem_rdata, bus.mem_err); else passes++;
  endtask

  task automatic test_bad_addr();
    bad_list[0] = 32'h0000_0002; bad_list[1] = 32'h8000_0000; bad_list[2] = 32'h0000_1000;
    for (int b = 0; b < 3; b++) begin
      cyc();
      bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = bad_list[b];
      #1;
      checks++; if ({bus.mem_gnt, bus.ram_en} !== 2'b10) $display("FAIL bad_port%0d: got %b want 10", b, {bus.mem_gnt, bus.ram_en}); else passes++;
      cyc(); idle(); #1;
      checks++; if ({bus.mem_err, bus.mem_rvalid} !== 2'b11 || bus.mem_rdata !== 32'h0)
        $display("FAIL bad_resp%0d: got %b/%h want 11/0", b, {bus.mem_err, bus.mem_rvalid}, bus.mem_rdata); else passes++;
    end
    cyc();
    checks++; if (bus.mem_err !== 1'b0) $display("FAIL bad_pulse: got %b want 0", bus.mem_err); else passes++;
  endtask

  task automatic test_flush();
    cyc();
    bus.if_req = 1; bus.if_addr = 32'h10;
    #1;
    checks++; if (bus.if_gnt !== 1'b1) $display("FAIL flush_gnt: got %b want 1", bus.if_gnt); else passes++;
    cyc(); bus.if_req = 0; bus.if_flush = 1; #1;
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'hA000_000D) $display("FAIL flush_resp: got %b/%h want 0/a000000d", bus.if_rvalid, bus.if_rdata); else passes++;
    cyc(); bus.if_flush = 0;
    // Flush in the grant cycle
    cyc();
    bus.if_req = 1; bus.if_addr = 32'h14; bus.if_flush = 1;
    #1;
    checks++; if (bus.if_gnt !== 1'b1) $display("FAIL flushg_gnt: got %b want 1", bus.if_gnt); else passes++;
    cyc(); idle(); #1;
    checks++; if (bus.if_rvalid !== 1'b0) $display("FAIL flushg_resp: got %b want 0", bus.if_rvalid); else passes++;
  endtask

  task automatic test_reset_inflight();
    cyc();
    bus.mem_req = 1; bus.mem_addr = 32'h44;
    #1;
    checks++; if (bus.mem_gnt !== 1'b1) $display("FAIL rst_gnt: got %b want 1", bus.mem_gnt); else passes++;
    cyc(); idle(); reset = 1; #1;
    checks++; if (bus.mem_rvalid !== 1'b0 || bus.mem_rdata !== 32'h0) $display("FAIL rst_resp: got %b/%h want 0/0", bus.mem_rvalid, bus.mem_rdata); else passes++;
    cyc(); reset = 0; #1;
    test_reset();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + 32'(i);
    bus.ram_rdata = 0;
    reset = 1;
    idle();
    repeat (3) cyc();
    test_reset();
    reset = 0;
    test_fetch();
    test_conflict();
    test_starvation();
    test_store_load();
    test_top_word();
    test_bad_addr();
    test_flush();
    test_reset_inflight();
    cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
